// File: rtl/iter_shifter_if.sv
// iter_shifter request/result bundle.
// master drives the request, slave is the shifter.
interface iter_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [SW-1:0]    shamt;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, data_in, shamt, mode,
    input  busy, done, result
  );

  modport slave (
    input  start, data_in, shamt, mode,
    output busy, done, result
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shifter, up to STEP bits per clock (SLL/SRL/SRA/ROTR).
// ITER_SHIFTER_ROTATE_EN enables ROTR; otherwise mode 11 acts as SRL.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  iter_shifter_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  typedef logic [SW:0] cnt_t;
  localparam cnt_t STEPC = cnt_t'(STEP);
  localparam cnt_t WIDC  = cnt_t'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_shf;
  logic [WIDTH-1:0] rsh;
  logic [SW-1:0]    rem;
  logic [SW-1:0]    n;
  logic [1:0]       mode_q;
  logic             accept;

  assign accept = (state != SHIFT) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start)
          state_nxt = (bus.shamt != '0) ? SHIFT : DONE;
        else
          state_nxt = IDLE;
      end
      SHIFT: begin
        if (rem == n) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state == SHIFT);
    bus.done   = (state == DONE);
    bus.result = res;
  end

  // n never exceeds rem, so the STEPC truncation only
  // matters when STEP == WIDTH, where it is unreachable.
  always_comb begin
    n = ({1'b0, rem} > STEPC) ? STEPC[SW-1:0] : rem;
  end

  always_comb begin
    rsh     = res >> n;
    res_shf = rsh;
    unique case (mode_q)
      2'b00: res_shf = res << n;
      2'b01: res_shf = rsh;
      2'b10: res_shf = WIDTH'($signed(res) >>> n);
      2'b11: begin
`ifdef ITER_SHIFTER_ROTATE_EN
        res_shf = rsh | (res << (WIDC - {1'b0, n}));
`else
        res_shf = rsh;
`endif
      end
      default: res_shf = rsh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res    <= '0;
      rem    <= '0;
      mode_q <= 2'b00;
    end else if (accept) begin
      res    <= bus.data_in;
      rem    <= bus.shamt;
      mode_q <= bus.mode;
    end else if (state == SHIFT) begin
      res <= res_shf;
      rem <= rem - n;
    end
  end
endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (WIDTH=32, STEP=4).
// Random and directed operations against an arithmetic model.
module tb_iter_shifter;
  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  iter_shifter_if #(.WIDTH(WIDTH)) bus ();

  iter_shifter #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [31:0] d,
                                        input int s,
                                        input logic [1:0] m);
    logic [63:0] dd;
    case (m)
      2'd0: return d << s;
      2'd1: return d >> s;
      2'd2: return 32'($signed(d) >>> s);
      default: begin
`ifdef ITER_SHIFTER_ROTATE_EN
        dd = {d, d} >> s;
        return dd[31:0];
`else
        return d >> s;
`endif
      end
    endcase
  endfunction

  // Call at a negedge: presents a request for the next posedge.
  task automatic launch(input logic [31:0] d,
                        input int s,
                        input logic [1:0] m);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.shamt   = 5'(s);
    bus.mode    = m;
  endtask

  // Follows one accepted op to its done cycle. With hold=1 it
  // returns at the done-cycle negedge so the caller can relaunch.
  task automatic finish_op(input logic [31:0] d,
                           input int s,
                           input logic [1:0] m,
                           input bit hold);
    int nb;
    logic [31:0] exp;
    nb  = (s + STEP - 1) / STEP;
    exp = model(d, s, m);
    @(posedge clk);
    for (int k = 1; k <= nb + 1; k++) begin
      @(negedge clk);
      check($sformatf("busy_done s=%0d k=%0d", s, k),
            {30'd0, bus.busy, bus.done},
            {30'd0, (k <= nb), (k == nb + 1)});
      if (k <= nb) begin
        bus.start   = 1'($urandom);
        bus.data_in = $urandom;
        bus.shamt   = 5'($urandom);
        bus.mode    = 2'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    check($sformatf("result d=%h s=%0d m=%0d", d, s, m),
          bus.result, exp);
    if (!hold) begin
      @(negedge clk);
      check("idle_after_done", {30'd0, bus.busy, bus.done}, 32'd0);
      check("result_held", bus.result, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] d,
                        input int s,
                        input logic [1:0] m);
    launch(d, s, m);
    finish_op(d, s, m, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    int s;
    logic [1:0] m;
    n_chk       = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.shamt   = '0;
    bus.mode    = '0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {30'd0, bus.busy, bus.done}, 32'd0);

    // start on the first edge after reset release
    rst_n = 1'b1;
    run_op(32'h0000_0001, 2, 2'd0);
    check("sll_2", bus.result, 32'h0000_0004);

    run_op(32'h8000_0000, 31, 2'd2);
    check("sra_31", bus.result, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 31, 2'd1);
    check("srl_31", bus.result, 32'h0000_0001);

    for (int i = 0; i < 4; i++)
      run_op(32'h1234_5678, 0, 2'(i));

    run_op(32'h0000_00F1, 4, 2'd3);
`ifdef ITER_SHIFTER_ROTATE_EN
    check("rotr_4", bus.result, 32'h1000_000F);
`else
    check("rotr_4", bus.result, 32'h0000_000F);
`endif

    // back-to-back: start held high through DONE
    launch(32'hA5A5_0F0F, 5, 2'd3);
    finish_op(32'hA5A5_0F0F, 5, 2'd3, 1'b1);
    launch(32'h8765_4321, 9, 2'd2);
    finish_op(32'h8765_4321, 9, 2'd2, 1'b1);
    launch(32'h0000_FFFF, 0, 2'd0);
    finish_op(32'h0000_FFFF, 0, 2'd0, 1'b0);

    // reset in the middle of a shift
    launch(32'h8000_0000, 31, 2'd2);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", bus.result, 32'd0);
    check("midrst_flags", {30'd0, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("no_done_after_rst", {30'd0, bus.busy, bus.done}, 32'd0);
    end
    run_op(32'hDEAD_BEEF, 13, 2'd1);

    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      s = int'($urandom_range(0, 31));
      m = 2'($urandom);
      run_op(d, s, m);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
